// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
package wb_pkg;
    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int NREG   = 1 << AW;
    localparam int QDEPTH = 4;
    localparam int STARVE = 8;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; DEPTH must be a power of two.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  wb_req_t                din_i,
    output wb_req_t                dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    // Storage array, no reset needed: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline results win the regfile port, long-latency
// results queue behind them; a scoreboard tracks pending long-latency writes.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int QD  = QDEPTH,
    parameter int STV = STARVE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we_i,
    input  logic [AW-1:0]   pipe_wa_i,
    input  logic [DW-1:0]   pipe_wd_i,
    input  logic            lng_valid_i,
    output logic            lng_ready_o,
    input  logic [AW-1:0]   lng_wa_i,
    input  logic [DW-1:0]   lng_wd_i,
    input  logic            iss_valid_i,
    input  logic [AW-1:0]   iss_wa_i,
    output logic [NREG-1:0] busy_o,
    output logic            starve_o,
    output logic            regwrite_o,
    output logic [AW-1:0]   wa_o,
    output logic [DW-1:0]   wd_o
);
    localparam int CW = $clog2(QD) + 1;
    localparam int SW = $clog2(STV + 1);

    wb_req_t         head, lng_req;
    logic            q_full, q_empty;
    logic [CW-1:0]   q_count;
    logic            pipe_wr, enq, deq;

    logic            regwrite_q, regwrite_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [DW-1:0]   wd_q, wd_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            starve_q;

    // A write to $0 is not a write: it neither reaches the port nor blocks the queue.
    assign pipe_wr     = pipe_we_i && (pipe_wa_i != REG_ZERO);
    assign lng_ready_o = !q_full;
    assign enq         = lng_valid_i && lng_ready_o && (lng_wa_i != REG_ZERO);
    assign deq         = !pipe_wr && !q_empty;
    assign lng_req     = '{wa: lng_wa_i, wd: lng_wd_i};

    wb_fifo #(.DEPTH(QD)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (enq),
        .pop_i   (deq),
        .din_i   (lng_req),
        .dout_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // Port priority mux, scoreboard update and starve counter next state.
    always_comb begin
        regwrite_d   = 1'b0;
        wa_d         = wa_q;
        wd_d         = wd_q;
        busy_d       = busy_q;
        starve_cnt_d = starve_cnt_q;

        if (pipe_wr) begin
            regwrite_d = 1'b1;
            wa_d       = pipe_wa_i;
            wd_d       = pipe_wd_i;
        end else if (deq) begin
            regwrite_d = 1'b1;
            wa_d       = head.wa;
            wd_d       = head.wd;
        end

        // Clear first so a same-cycle issue to the same register wins.
        if (deq) busy_d[head.wa] = 1'b0;
        if (iss_valid_i && (iss_wa_i != REG_ZERO)) busy_d[iss_wa_i] = 1'b1;
        busy_d[0] = 1'b0;

        if (deq || q_empty) starve_cnt_d = '0;
        else if (starve_cnt_q != SW'(STV)) starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_q   <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            busy_q       <= '0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            regwrite_q   <= regwrite_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= (starve_cnt_d == SW'(STV));
        end
    end

    assign regwrite_o = regwrite_q;
    assign wa_o       = wa_q;
    assign wd_o       = wd_q;
    assign busy_o     = busy_q;
    assign starve_o   = starve_q;

    // Protocol rules the surrounding pipeline must honour.
    a_iss_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (iss_valid_i && iss_wa_i != REG_ZERO) |->
            (!busy_q[iss_wa_i] || (deq && head.wa == iss_wa_i)));
    a_pipe_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        pipe_wr |-> !busy_q[pipe_wa_i]);
    a_lng_busy: assert property (@(posedge clk) disable iff (!rst_n)
        enq |-> busy_q[lng_wa_i]);
    a_full_count: assert property (@(posedge clk) disable iff (!rst_n)
        q_full == (q_count == CW'(QD)));
endmodule
